// File: rtl/pipeline_uart_sender.sv
// pipeline_uart_sender: serial transmit end of the CPU UART path.
// Accepts a byte on a one-cycle TX_EN strobe while idle and shifts it out
// as an 8N1 frame (start, 8 data bits LSB first, stop) on UART_TX.
// Build option: define UART_SENDER_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (11-bit frame).
//
// Ports:
//   clk        system clock, all state on rising edge
//   reset      asynchronous active-high reset
//   TX_DATA    byte to send, sampled only on an accepted TX_EN
//   TX_EN      send request, level-sampled each edge
//   TX_STATUS  1 = idle and ready, 0 = frame in progress (registered)
//   UART_TX    serial line, idle high (registered)
module pipeline_uart_sender #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] TX_DATA,
  input  logic       TX_EN,
  output logic       TX_STATUS,
  output logic       UART_TX
);

`ifdef UART_SENDER_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             status_q, status_d;
  logic             wrap;
`ifdef UART_SENDER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign wrap      = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign UART_TX   = tx_q;
  assign TX_STATUS = status_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    status_d  = status_q;
`ifdef UART_SENDER_PARITY_EN
    parity_d  = parity_q;
`endif
    if (state_q != StIdle) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end
    case (state_q)
      StIdle: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (TX_EN) begin
          shift_d  = TX_DATA;
          state_d  = StStart;
          tx_d     = 1'b0;
          status_d = 1'b0;
`ifdef UART_SENDER_PARITY_EN
          parity_d = ^TX_DATA;
`endif
        end
      end
      StStart: begin
        if (wrap) begin
          state_d = StData;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (wrap) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_SENDER_PARITY_EN
            state_d = StParity;
            tx_d    = parity_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            // Next bit is the one about to land in shift_q[0].
            tx_d      = shift_q[1];
          end
        end
      end
`ifdef UART_SENDER_PARITY_EN
      StParity: begin
        if (wrap) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
`endif
      StStop: begin
        // TX_EN on this edge is not accepted: state_q is still StStop.
        if (wrap) begin
          state_d  = StIdle;
          status_d = 1'b1;
          tx_d     = 1'b1;
        end
      end
      default: begin
        state_d  = StIdle;
        tx_d     = 1'b1;
        status_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      status_q  <= 1'b1;
`ifdef UART_SENDER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      status_q  <= status_d;
`ifdef UART_SENDER_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipeline_uart_sender.sv
// Directed self-checking bench for pipeline_uart_sender with CLKS_PER_BIT = 4.
// Frame vectors are hand-computed: bit i of a vector is the line level during
// bit period i after the accepting edge (start, data LSB first, [parity], stop).
module tb_pipeline_uart_sender;
  localparam int unsigned CPB = 4;
`ifdef UART_SENDER_PARITY_EN
  localparam int NBITS = 11;
  localparam logic [10:0] FRAME_A5 = 11'b10101001010;
  localparam logic [10:0] FRAME_3C = 11'b10001111000;
  localparam logic [10:0] FRAME_07 = 11'b11000001110;
  localparam logic [10:0] FRAME_03 = 11'b10000000110;
`else
  localparam int NBITS = 10;
  localparam logic [10:0] FRAME_A5 = 11'b01101001010;
  localparam logic [10:0] FRAME_3C = 11'b01001111000;
`endif
  localparam int FCYC = NBITS * CPB;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_status;
  logic       uart_tx;

  int errors = 0;
  int checks = 0;

  pipeline_uart_sender #(
    .CLKS_PER_BIT(CPB),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .TX_DATA(tx_data),
    .TX_EN(tx_en),
    .TX_STATUS(tx_status),
    .UART_TX(uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    tx_en = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (uart_tx !== 1'b1 || tx_status !== 1'b1) begin
        errors++;
        $display("FAIL reset_idle c=%0d: tx=%b status=%b, required tx=1 status=1",
                 c, uart_tx, tx_status);
      end
    end
  endtask

  // A5 frame with a second request (FF) injected mid-frame at k+10.
  task automatic test_single_frame();
    logic [10:0] exp;
    exp = FRAME_A5;
    @(negedge clk);
    tx_data = 8'hA5;
    tx_en = 1'b1;
    @(posedge clk);  // edge k
    for (int c = 0; c < FCYC; c++) begin
      @(negedge clk);
      if (c == 0) tx_en = 1'b0;
      checks++;
      if (uart_tx !== exp[c / CPB] || tx_status !== 1'b0) begin
        errors++;
        $display("FAIL single_frame c=%0d: tx=%b status=%b, required tx=%b status=0",
                 c, uart_tx, tx_status, exp[c / CPB]);
      end
      if (c == 9) begin
        tx_en = 1'b1;
        tx_data = 8'hFF;
      end
      if (c == 10) tx_en = 1'b0;
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (uart_tx !== 1'b1 || tx_status !== 1'b1) begin
        errors++;
        $display("FAIL single_after c=%0d: tx=%b status=%b, required tx=1 status=1",
                 c, uart_tx, tx_status);
      end
    end
  endtask

  // TX_EN held high: frames start at k and k+FCYC+1.
  task automatic test_back_to_back();
    logic [10:0] exp;
    exp = FRAME_3C;
    @(negedge clk);
    tx_data = 8'h3C;
    tx_en = 1'b1;
    @(posedge clk);  // edge k
    for (int c = 0; c < FCYC; c++) begin
      @(negedge clk);
      checks++;
      if (uart_tx !== exp[c / CPB] || tx_status !== 1'b0) begin
        errors++;
        $display("FAIL b2b_frame1 c=%0d: tx=%b status=%b, required tx=%b status=0",
                 c, uart_tx, tx_status, exp[c / CPB]);
      end
    end
    @(negedge clk);  // after edge k+FCYC: one idle cycle
    checks++;
    if (uart_tx !== 1'b1 || tx_status !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: tx=%b status=%b, required tx=1 status=1", uart_tx, tx_status);
    end
    for (int c = 0; c < FCYC; c++) begin
      @(negedge clk);
      if (c == 20) tx_en = 1'b0;
      checks++;
      if (uart_tx !== exp[c / CPB] || tx_status !== 1'b0) begin
        errors++;
        $display("FAIL b2b_frame2 c=%0d: tx=%b status=%b, required tx=%b status=0",
                 c, uart_tx, tx_status, exp[c / CPB]);
      end
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (uart_tx !== 1'b1 || tx_status !== 1'b1) begin
        errors++;
        $display("FAIL b2b_after c=%0d: tx=%b status=%b, required tx=1 status=1",
                 c, uart_tx, tx_status);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] exp;
    exp = FRAME_A5;
    @(negedge clk);
    tx_data = 8'hA5;
    tx_en = 1'b1;
    @(posedge clk);  // edge k
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (c == 0) tx_en = 1'b0;
      checks++;
      if (uart_tx !== exp[c / CPB] || tx_status !== 1'b0) begin
        errors++;
        $display("FAIL midrst_pre c=%0d: tx=%b status=%b, required tx=%b status=0",
                 c, uart_tx, tx_status, exp[c / CPB]);
      end
    end
    #1 reset = 1'b1;
    #1;  // still before the next rising edge
    checks++;
    if (uart_tx !== 1'b1 || tx_status !== 1'b1) begin
      errors++;
      $display("FAIL midrst_async: tx=%b status=%b, required tx=1 status=1",
               uart_tx, tx_status);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tx_data = 8'h3C;
    tx_en = 1'b1;
    exp = FRAME_3C;
    @(posedge clk);
    for (int c = 0; c < FCYC; c++) begin
      @(negedge clk);
      if (c == 0) tx_en = 1'b0;
      checks++;
      if (uart_tx !== exp[c / CPB] || tx_status !== 1'b0) begin
        errors++;
        $display("FAIL midrst_post c=%0d: tx=%b status=%b, required tx=%b status=0",
                 c, uart_tx, tx_status, exp[c / CPB]);
      end
    end
    @(negedge clk);
    checks++;
    if (uart_tx !== 1'b1 || tx_status !== 1'b1) begin
      errors++;
      $display("FAIL midrst_done: tx=%b status=%b, required tx=1 status=1", uart_tx, tx_status);
    end
  endtask

`ifdef UART_SENDER_PARITY_EN
  task automatic test_parity();
    logic [10:0] exp;
    logic [7:0]  data;
    for (int f = 0; f < 2; f++) begin
      data = (f == 0) ? 8'h07 : 8'h03;
      exp  = (f == 0) ? FRAME_07 : FRAME_03;
      @(negedge clk);
      tx_data = data;
      tx_en = 1'b1;
      @(posedge clk);
      for (int c = 0; c < FCYC; c++) begin
        @(negedge clk);
        if (c == 0) tx_en = 1'b0;
        checks++;
        if (uart_tx !== exp[c / CPB] || tx_status !== 1'b0) begin
          errors++;
          $display("FAIL parity %h c=%0d: tx=%b status=%b, required tx=%b status=0",
                   data, c, uart_tx, tx_status, exp[c / CPB]);
        end
      end
      @(negedge clk);
      checks++;
      if (uart_tx !== 1'b1 || tx_status !== 1'b1) begin
        errors++;
        $display("FAIL parity_done %h: tx=%b status=%b, required tx=1 status=1",
                 data, uart_tx, tx_status);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_SENDER_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
